counter_scheduler: RTL and testbench



---
 rtl/counter_scheduler_pkg.sv | 22 ++
 rtl/counter_scheduler_rr_arbiter.sv | 32 +++
 rtl/counter_scheduler.sv | 99 +++++++++
 tb/tb_counter_scheduler.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/counter_scheduler_pkg.sv
// Shared types and helpers for the shared-counter scheduler.
package counter_scheduler_pkg;

    localparam int unsigned DEFAULT_NUM_REQ = 4;
    localparam int unsigned DEFAULT_WIDTH   = 8;
    localparam int unsigned MAX_REQ         = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Binary requester index to a one-hot vector sized for the largest configuration.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/counter_scheduler_rr_arbiter.sv
// Combinational round-robin pick: searches from ptr+1 upward, wrapping at NUM_REQ.
module rr_arbiter
    import counter_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [IDX_W-1:0] cand;

    // First requester found after the last winner takes the grant.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        gnt = valid ? NUM_REQ'(onehot(4'(idx))) : '0;
    end

endmodule

// File: rtl/counter_scheduler.sv
// Time-shares one 0..Target up-counter among NUM_REQ round-robin requesters.
module counter_scheduler
    import counter_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    parameter int unsigned WIDTH   = DEFAULT_WIDTH
) (
    input  logic                     Clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [NUM_REQ*WIDTH-1:0] Len,
    output logic [NUM_REQ-1:0]       Gnt,
    output logic [NUM_REQ-1:0]       Done,
    output logic                     Busy,
    output logic [WIDTH-1:0]         Count
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   win;
    logic [WIDTH-1:0]   target;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (Req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Scheduler FSM with the shared counter and all outputs registered.
    always_ff @(posedge Clk) begin
        if (rst) begin
            state  <= IDLE;
            Gnt    <= '0;
            Done   <= '0;
            Busy   <= 1'b0;
            Count  <= '0;
            ptr    <= IDX_W'(NUM_REQ - 1);
            win    <= '0;
            target <= '0;
        end else begin
            case (state)
                IDLE: begin
                    Done  <= '0;
                    Count <= '0;
                    if (arb_valid) begin
                        Gnt    <= arb_gnt;
                        Busy   <= 1'b1;
                        win    <= arb_idx;
                        ptr    <= arb_idx;
                        target <= Len[arb_idx*WIDTH +: WIDTH];
                        state  <= RUN;
                    end else begin
                        Gnt  <= '0;
                        Busy <= 1'b0;
                    end
                end
                RUN: begin
                    if (!Req[win]) begin
                        Gnt   <= '0;
                        Busy  <= 1'b0;
                        Count <= '0;
                        state <= IDLE;
                    end else if (Count == target) begin
                        // Compare precedes increment, so an all-ones target never wraps.
                        Done  <= Gnt;
                        state <= DONE;
                    end else begin
                        Count <= Count + WIDTH'(1);
                    end
                end
                DONE: begin
                    Done  <= '0;
                    Gnt   <= '0;
                    Busy  <= 1'b0;
                    Count <= '0;
                    state <= IDLE;
                end
                default: begin
                    Done  <= '0;
                    Gnt   <= '0;
                    Busy  <= 1'b0;
                    Count <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed vector table plus hand-written multi-cycle sequences for counter_scheduler.
module tb_counter_scheduler;

    localparam int NR = 4;
    localparam int W  = 8;

    typedef struct {
        logic          rst;
        logic [NR-1:0] req;
        logic [NR-1:0] gnt;
        logic [NR-1:0] done;
        logic          busy;
        logic [W-1:0]  count;
    } vec_t;

    logic            Clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   Req = '0;
    logic [NR*W-1:0] Len = '0;
    logic [NR-1:0]   Gnt;
    logic [NR-1:0]   Done;
    logic            Busy;
    logic [W-1:0]    Count;

    int tests = 0;
    int fails = 0;

    counter_scheduler #(
        .NUM_REQ (NR),
        .WIDTH   (W)
    ) dut (
        .Clk   (Clk),
        .rst   (rst),
        .Req   (Req),
        .Len   (Len),
        .Gnt   (Gnt),
        .Done  (Done),
        .Busy  (Busy),
        .Count (Count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] g,
                                input logic [3:0] d, input logic b, input logic [7:0] c);
        vec_t v;
        v.rst = r; v.req = q; v.gnt = g; v.done = d; v.busy = b; v.count = c;
        return v;
    endfunction

    vec_t vecs[$];
    int   gidx[$];
    int   gcyc[$];
    logic [NR-1:0] prev_gnt;
    int   bad;
    int   hit;

    initial begin
        // Len: r3=3, r2=0, r1=10, r0=5. Expected values are outputs after the edge.
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 1, 0));
        vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 1, 1));
        vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 1, 2));
        vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 1, 3));
        vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 1, 4));
        vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 1, 5));
        vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 1, 5));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 1, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b0100, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0110, 4'b0010, 4'b0000, 1, 0));
        vecs.push_back(mk(0, 4'b0110, 4'b0010, 4'b0000, 1, 1));
        vecs.push_back(mk(0, 4'b0110, 4'b0010, 4'b0000, 1, 2));
        vecs.push_back(mk(0, 4'b0110, 4'b0010, 4'b0000, 1, 3));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 1, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b0100, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0));

        Len = {8'd3, 8'd0, 8'd10, 8'd5};
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            Req = vecs[i].req;
            tick();
            check($sformatf("vec%0d gnt", i),   32'(Gnt),   32'(vecs[i].gnt));
            check($sformatf("vec%0d done", i),  32'(Done),  32'(vecs[i].done));
            check($sformatf("vec%0d busy", i),  32'(Busy),  32'(vecs[i].busy));
            check($sformatf("vec%0d count", i), 32'(Count), 32'(vecs[i].count));
        end

        // Round-robin with all requesters held, Len=2 everywhere.
        rst = 1'b1; Req = '0; Len = {4{8'd2}};
        tick();
        rst = 1'b0; Req = 4'b1111;
        prev_gnt = '0;
        for (int c = 0; c < 40 && gidx.size() < 5; c++) begin
            tick();
            if (Gnt != '0 && prev_gnt == '0) begin
                for (int b = 0; b < NR; b++) if (Gnt[b]) gidx.push_back(b);
                gcyc.push_back(c);
            end
            prev_gnt = Gnt;
        end
        check("rr grant count", 32'(gidx.size()), 32'd5);
        if (gcyc.size() > 0) check("rr first grant cycle", 32'(gcyc[0]), 32'd0);
        for (int k = 0; k < gidx.size(); k++) begin
            check($sformatf("rr grant%0d idx", k), 32'(gidx[k]), 32'(k % NR));
            if (k > 0) check($sformatf("rr grant%0d spacing", k), 32'(gcyc[k] - gcyc[k-1]), 32'd5);
        end

        // Reset in the middle of a run.
        rst = 1'b1; Req = '0;
        tick();
        rst = 1'b0; Len = {8'd0, 8'd0, 8'd0, 8'd10}; Req = 4'b0001;
        hit = 0;
        for (int c = 0; c < 20 && hit == 0; c++) begin
            tick();
            if (Count == 8'd4) hit = 1;
        end
        check("midrun reached count4", 32'(hit), 32'd1);
        rst = 1'b1;
        tick();
        check("midrun rst gnt",   32'(Gnt),   32'd0);
        check("midrun rst done",  32'(Done),  32'd0);
        check("midrun rst busy",  32'(Busy),  32'd0);
        check("midrun rst count", 32'(Count), 32'd0);
        rst = 1'b0; Req = 4'b1001;
        tick();
        check("post rst grant", 32'(Gnt), 32'b0001);
        check("post rst busy",  32'(Busy), 32'd1);

        // Full 8-bit range; Len rewritten after grant must be ignored.
        rst = 1'b1; Req = '0;
        tick();
        rst = 1'b0; Len = {8'd255, 8'd0, 8'd0, 8'd0}; Req = 4'b1000;
        tick();
        check("full grant",       32'(Gnt),   32'b1000);
        check("full grant count", 32'(Count), 32'd0);
        Len = {4{8'd7}};
        bad = 0;
        for (int k = 1; k <= 255; k++) begin
            tick();
            if (Count !== 8'(k) || Gnt !== 4'b1000 || Done !== 4'b0000) bad++;
        end
        check("full ramp errors", 32'(bad), 32'd0);
        tick();
        check("full done",       32'(Done),  32'b1000);
        check("full done count", 32'(Count), 32'd255);
        Req = '0;
        tick();
        check("full idle busy",  32'(Busy),  32'd0);
        check("full idle done",  32'(Done),  32'd0);
        check("full idle count", 32'(Count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
